up3_ctrl: RTL and testbench

- Microsequencer for the UP3 accumulator datapath.
- Replaces the manual SW[6:0] control switches: drives STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL, LOAD_IRU and LOAD_AC from the decoded opcode and the ALU flags.
- Fixed 6-cycle fetch/decode/execute per instruction; RAM is synchronous with 1-cycle read latency.
- Supports free-run, single-step and halt.

---
 rtl/up3_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_up3_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/up3_ctrl.sv
// rtl/up3_ctrl.sv - UP3 accumulator microsequencer
// Six-cycle fetch/decode/execute controller with run, single-step and halt.
module up3_ctrl #(
  parameter int unsigned ILLEGAL_AS_NOP = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [4:0] opcode,
  input  logic       zflg,
  input  logic       nflg,
  output logic       STORE_MEM,
  output logic       FETCH,
  output logic       INCR_PC,
  output logic       LOAD_PC,
  output logic       LOAD_IRL,
  output logic       LOAD_IRU,
  output logic       LOAD_AC,
  output logic       z_flag,
  output logic       n_flag,
  output logic       halted,
  output logic       ILLEGAL,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_FU_A = 4'd1,
    S_FU_L = 4'd2,
    S_FL_A = 4'd3,
    S_FL_L = 4'd4,
    S_DEC  = 4'd5,
    S_EXE  = 4'd6,
    S_HALT = 4'd7
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LDA  = 5'h01;
  localparam logic [4:0] OP_STA  = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_SUB  = 5'h04;
  localparam logic [4:0] OP_AND  = 5'h05;
  localparam logic [4:0] OP_OR   = 5'h06;
  localparam logic [4:0] OP_LDI  = 5'h08;
  localparam logic [4:0] OP_ADDI = 5'h09;
  localparam logic [4:0] OP_SUBI = 5'h0A;
  localparam logic [4:0] OP_JMP  = 5'h10;
  localparam logic [4:0] OP_JZ   = 5'h11;
  localparam logic [4:0] OP_JN   = 5'h12;
  localparam logic [4:0] OP_HALT = 5'h1F;

  state_t r_state;
  logic   r_store_mem;
  logic   r_fetch;
  logic   r_incr_pc;
  logic   r_load_pc;
  logic   r_load_irl;
  logic   r_load_iru;
  logic   r_load_ac;
  logic   r_z_flag;
  logic   r_n_flag;
  logic   r_halted;
  logic   r_illegal;

  state_t w_next_state;
  logic   w_store_mem;
  logic   w_fetch;
  logic   w_incr_pc;
  logic   w_load_pc;
  logic   w_load_irl;
  logic   w_load_iru;
  logic   w_load_ac;
  logic   w_set_illegal;
  logic   w_legal;
  logic   w_is_alu;

  always_comb begin
    w_legal  = 1'b0;
    w_is_alu = 1'b0;
    case (opcode)
      OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDI, OP_ADDI, OP_SUBI: begin
        w_legal  = 1'b1;
        w_is_alu = 1'b1;
      end
      OP_NOP, OP_STA, OP_JMP, OP_JZ, OP_JN, OP_HALT: w_legal = 1'b1;
      default: ;
    endcase
  end

  // Next state, then the controls that the next state will drive.
  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE: if (run || step) w_next_state = S_FU_A;
      S_FU_A: w_next_state = S_FU_L;
      S_FU_L: w_next_state = S_FL_A;
      S_FL_A: w_next_state = S_FL_L;
      S_FL_L: w_next_state = S_DEC;
      S_DEC: begin
        if (w_legal || (ILLEGAL_AS_NOP != 0)) begin
          w_next_state = S_EXE;
        end else begin
          w_next_state  = S_HALT;
          w_set_illegal = 1'b1;
        end
      end
      S_EXE: begin
        if (opcode == OP_HALT) w_next_state = S_HALT;
        else if (run)          w_next_state = S_FU_A;
        else                   w_next_state = S_IDLE;
      end
      S_HALT: w_next_state = S_HALT;
      default: w_next_state = S_IDLE;
    endcase

    w_store_mem = 1'b0;
    w_fetch     = 1'b0;
    w_incr_pc   = 1'b0;
    w_load_pc   = 1'b0;
    w_load_irl  = 1'b0;
    w_load_iru  = 1'b0;
    w_load_ac   = 1'b0;
    case (w_next_state)
      S_FU_A, S_FL_A: w_fetch = 1'b1;
      S_FU_L: begin
        w_fetch    = 1'b1;
        w_load_iru = 1'b1;
        w_incr_pc  = 1'b1;
      end
      S_FL_L: begin
        w_fetch    = 1'b1;
        w_load_irl = 1'b1;
        w_incr_pc  = 1'b1;
      end
      S_EXE: begin
        w_load_ac   = w_is_alu;
        w_store_mem = (opcode == OP_STA);
        w_load_pc   = (opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && r_z_flag) ||
                      ((opcode == OP_JN) && r_n_flag);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_store_mem <= 1'b0;
      r_fetch     <= 1'b0;
      r_incr_pc   <= 1'b0;
      r_load_pc   <= 1'b0;
      r_load_irl  <= 1'b0;
      r_load_iru  <= 1'b0;
      r_load_ac   <= 1'b0;
      r_z_flag    <= 1'b0;
      r_n_flag    <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_store_mem <= w_store_mem;
      r_fetch     <= w_fetch;
      r_incr_pc   <= w_incr_pc;
      r_load_pc   <= w_load_pc;
      r_load_irl  <= w_load_irl;
      r_load_iru  <= w_load_iru;
      r_load_ac   <= w_load_ac;
      r_halted    <= (w_next_state == S_HALT);
      if (w_set_illegal) r_illegal <= 1'b1;
      if ((r_state == S_EXE) && r_load_ac) begin
        r_z_flag <= zflg;
        r_n_flag <= nflg;
      end
    end
  end

  // Controls are masked while reset is high so an aborted EXE never writes.
  assign STORE_MEM = r_store_mem & ~reset;
  assign FETCH     = r_fetch     & ~reset;
  assign INCR_PC   = r_incr_pc   & ~reset;
  assign LOAD_PC   = r_load_pc   & ~reset;
  assign LOAD_IRL  = r_load_irl  & ~reset;
  assign LOAD_IRU  = r_load_iru  & ~reset;
  assign LOAD_AC   = r_load_ac   & ~reset;
  assign z_flag    = r_z_flag;
  assign n_flag    = r_n_flag;
  assign halted    = r_halted;
  assign ILLEGAL   = r_illegal;
  assign state     = r_state;

endmodule

// File: tb/tb_up3_ctrl.sv
// tb/tb_up3_ctrl.sv - directed bench for up3_ctrl with a UP3 datapath model
module tb_up3_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [4:0] opcode;
  logic       zflg;
  logic       nflg;
  logic       STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL, LOAD_IRU, LOAD_AC;
  logic       z_flag, n_flag, halted, ILLEGAL;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int cnt;

  logic [7:0] prog [256];
  logic [7:0] mem  [256];
  logic       ld = 1'b0;
  logic [7:0] pc, iru, irl, ac, mem_q, alu;
  logic [6:0] ctrl;

  up3_ctrl #(.ILLEGAL_AS_NOP(0)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
    .zflg(zflg), .nflg(nflg), .STORE_MEM(STORE_MEM), .FETCH(FETCH),
    .INCR_PC(INCR_PC), .LOAD_PC(LOAD_PC), .LOAD_IRL(LOAD_IRL),
    .LOAD_IRU(LOAD_IRU), .LOAD_AC(LOAD_AC), .z_flag(z_flag), .n_flag(n_flag),
    .halted(halted), .ILLEGAL(ILLEGAL), .state(state)
  );

  always #5 clk = ~clk;

  assign opcode = iru[4:0];
  assign ctrl   = {STORE_MEM, FETCH, INCR_PC, LOAD_PC, LOAD_IRL, LOAD_IRU, LOAD_AC};

  always_comb begin
    case (iru[4:0])
      5'h01:   alu = mem_q;
      5'h03:   alu = ac + mem_q;
      5'h04:   alu = ac - mem_q;
      5'h05:   alu = ac & mem_q;
      5'h06:   alu = ac | mem_q;
      5'h08:   alu = irl;
      5'h09:   alu = ac + irl;
      5'h0A:   alu = ac - irl;
      default: alu = ac;
    endcase
  end
  assign zflg = (alu == 8'h00);
  assign nflg = alu[7];

  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) mem[i] <= prog[i];
    end else if (STORE_MEM) begin
      mem[irl] <= ac;
    end
    mem_q <= mem[FETCH ? pc : irl];
    if (reset) begin
      pc  <= 8'h00;
      iru <= 8'h00;
      irl <= 8'h00;
      ac  <= 8'h00;
    end else begin
      if (INCR_PC)      pc <= pc + 8'h01;
      else if (LOAD_PC) pc <= irl;
      if (LOAD_IRU) iru <= mem_q;
      if (LOAD_IRL) irl <= mem_q;
      if (LOAD_AC)  ac  <= alu;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  task automatic commit_and_reset();
    ld = 1'b1;
    reset = 1'b1;
    run = 1'b0;
    step = 1'b0;
    tick();
    ld = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and quiet idle
    clear_prog();
    ld = 1'b1;
    tick();
    ld = 1'b0;
    tick();
    check("rst state", 32'(state), 32'd0);
    check("rst ctrl", 32'(ctrl), 32'd0);
    check("rst flags", 32'({z_flag, n_flag, halted, ILLEGAL}), 32'd0);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle state+ctrl", 32'({state, ctrl}), 32'd0);
    end

    // LDI 5; ADDI 3
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h05; prog[2] = 8'h09; prog[3] = 8'h03;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("t2 state", 32'(state), 32'(((c - 1) % 6) + 1));
      check("t2 load_ac", 32'(LOAD_AC), 32'((c == 6) || (c == 12)));
      if (c == 7) begin
        check("t2 ac after i1", 32'(ac), 32'h05);
        run = 1'b0;
      end
    end
    tick();
    check("t2 ac after i2", 32'(ac), 32'h08);
    check("t2 pc", 32'(pc), 32'h04);
    check("t2 idle", 32'(state), 32'd0);
    check("t2 z_flag", 32'(z_flag), 32'd0);

    // LDI 0; JZ 0x20; HALT at 0x20
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h00; prog[2] = 8'h11; prog[3] = 8'h20;
    prog[8'h20] = 8'h1F;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 7)  check("t3 z_flag", 32'(z_flag), 32'd1);
      if (c == 13) check("t3 pc jz", 32'(pc), 32'h20);
    end
    tick();
    check("t3 halted", 32'(halted), 32'd1);
    check("t3 halt state", 32'(state), 32'd7);
    step = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t3 halt sticky", 32'({state, ctrl}), 32'({4'd7, 7'd0}));
    end
    step = 1'b0;

    // LDI 0; JN 0x20 not taken
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h00; prog[2] = 8'h12; prog[3] = 8'h20;
    prog[8'h20] = 8'h1F;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 7) run = 1'b0;
    end
    tick();
    check("t3 jn pc", 32'(pc), 32'h04);
    check("t3 jn idle", 32'(state), 32'd0);
    check("t3 n_flag", 32'(n_flag), 32'd0);

    // LDI 0x7A; STA 0x40; LDA 0x40
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h7A; prog[2] = 8'h02; prog[3] = 8'h40;
    prog[4] = 8'h01; prog[5] = 8'h40;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      check("t4 store_mem", 32'(STORE_MEM), 32'(c == 12));
      check("t4 fetch", 32'(FETCH), 32'((((c - 1) % 6) + 1) <= 4));
      if (c == 13) run = 1'b0;
    end
    tick();
    check("t4 ac", 32'(ac), 32'h7A);
    check("t4 mem40", 32'(mem[8'h40]), 32'h7A);
    check("t4 idle", 32'(state), 32'd0);

    // Single step, with a dropped step during EXE
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h11;
    commit_and_reset();
    step = 1'b1;
    tick();
    step = 1'b0;
    check("t5 step latency", 32'(state), 32'd1);
    cnt = (state != 4'd0) ? 1 : 0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if (state != 4'd0) cnt++;
      if (c == 6) begin
        check("t5 exe", 32'(state), 32'd6);
        step = 1'b1;
      end else begin
        step = 1'b0;
      end
    end
    check("t5 busy cycles", 32'(cnt), 32'd6);
    check("t5 pc", 32'(pc), 32'h02);
    check("t5 ac", 32'(ac), 32'h11);
    check("t5 idle", 32'(state), 32'd0);

    // Illegal opcode 0x1C halts after DEC
    clear_prog();
    prog[0] = 8'h1C; prog[1] = 8'h00;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 5; c++) tick();
    check("t6 dec", 32'(state), 32'd5);
    tick();
    check("t6 halt", 32'(state), 32'd7);
    check("t6 illegal", 32'(ILLEGAL), 32'd1);
    check("t6 halted", 32'(halted), 32'd1);
    tick();
    tick();
    check("t6 stays halted", 32'({state, ctrl}), 32'({4'd7, 7'd0}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6 illegal cleared", 32'(ILLEGAL), 32'd0);
    check("t6 reset idle", 32'(state), 32'd0);
    for (int c = 1; c <= 3; c++) tick();
    check("t6 fl_a", 32'(state), 32'd3);
    reset = 1'b1;
    tick();
    check("t6 abort state", 32'(state), 32'd0);
    check("t6 abort ctrl", 32'(ctrl), 32'd0);
    check("t6 abort illegal", 32'(ILLEGAL), 32'd0);
    reset = 1'b0;
    run = 1'b0;

    // Reset during EXE of STA suppresses the write
    clear_prog();
    prog[0] = 8'h08; prog[1] = 8'h55; prog[2] = 8'h02; prog[3] = 8'h40;
    prog[8'h40] = 8'h33;
    commit_and_reset();
    run = 1'b1;
    for (int c = 1; c <= 12; c++) tick();
    check("t7 sta exe", 32'(STORE_MEM), 32'd1);
    reset = 1'b1;
    #1;
    check("t7 store masked", 32'(STORE_MEM), 32'd0);
    tick();
    reset = 1'b0;
    run = 1'b0;
    check("t7 mem40 kept", 32'(mem[8'h40]), 32'h33);
    check("t7 idle", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
